// File: rtl/sumador_pkg.sv
// sumador_pkg
// Shared definitions for the serial adder/subtractor:
//   state_t   - controller state encoding (IDLE, RUN, FIN)
//   cnt_width - width of the slice counter for a given number of steps
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // ceil(log2(steps)), never less than 1 so the counter always exists.
    function automatic int cnt_width(input int steps);
        int w;
        w = 1;
        while ((32'd1 << w) < steps) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sumador_serie_fa_chunk.sv
// fa_chunk
// Combinational CHUNK-bit ripple of full-adder cells.
// Ports:
//   a, b   in  CHUNK  operand slices
//   ci     in  1      carry in to bit 0
//   s      out CHUNK  sum slice
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (for overflow detection)
module fa_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    // Ripple chain: c[i] is the carry into bit i.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/sumador_serie.sv
// sumador_serie
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// LSB slice first, through a registered carry.
// Ports:
//   CLK    in  1      clock, rising edge
//   RST    in  1      synchronous active-high reset
//   START  in  1      request, honoured in IDLE or FIN
//   SUB    in  1      0: A+B+AE, 1: A-B-AE
//   A, B   in  WIDTH  operands, latched on an accepted START
//   AE     in  1      carry/borrow in
//   BUSY   out 1      high while in RUN
//   DONE   out 1      one-cycle pulse, results valid
//   SUMA   out WIDTH  result
//   AS     out 1      carry out (in SUB mode 1 = no borrow)
//   OV     out 1      two's-complement overflow
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             AE,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUMA,
    output logic             AS,
    output logic             OV
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = cnt_width(STEPS);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_cmsb;
    logic [WIDTH-1:0] work_next;
    logic             last_step;

    fa_chunk #(
        .CHUNK(CHUNK)
    ) u_fa (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_cmsb)
    );

    // New slices enter at the top of the working register, so after STEPS
    // shifts the first (LSB) slice has arrived at bit 0.
    assign work_next = (work >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
    assign last_step = (cnt == CW'(STEPS - 1));

    // Controller, datapath registers and registered outputs in one process.
    // IDLE and FIN share the accept path, which is what lets a START held in
    // FIN chain the next operation without an idle cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            SUMA  <= '0;
            AS    <= 1'b0;
            OV    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        // Subtraction becomes A + ~B + ~AE.
                        a_sh  <= A;
                        b_sh  <= B ^ {WIDTH{SUB}};
                        carry <= AE ^ SUB;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    carry <= slice_co;
                    work  <= work_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        SUMA  <= work_next;
                        AS    <= slice_co;
                        OV    <= slice_co ^ slice_cmsb;
                        state <= FIN;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sumador_serie.md
# sumador_serie

- Parametrised multi-cycle adder/subtractor.
- Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a registered carry.
- Trades latency for a small ripple datapath. It is the sequential, width-generic successor to the team's single-bit full-adder cells.
- Sits beside the ALU as the shared arithmetic unit, with a START/BUSY/DONE handshake toward the controller.

## Interface

Parameters:
- WIDTH, 8, operand and result width; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE or FIN.
- SUB  in  1  mode, latched with START: 0 gives A+B+AE, 1 gives A−B−AE.
- A  in  WIDTH  operand, latched on an accepted START.
- B  in  WIDTH  operand, latched on an accepted START.
- AE  in  1  carry/borrow in, latched on an accepted START.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse; results valid.
- SUMA  out  WIDTH  result.
- AS  out  1  carry out. In SUB mode: 1 means no borrow, 0 means borrow.
- OV  out  1  two's-complement overflow.

## Operation

States: IDLE, RUN, FIN.
- IDLE: START=1 latches operands, clears the step counter, goes to RUN.
  - Latched B is A-side-ready: B^{WIDTH{SUB}}.
  - Carry register gets AE^SUB.
- RUN: each edge adds one CHUNK slice of A, Bx and the carry register.
  - Result slice is written into the working register.
  - Carry register is updated.
  - Step counter increments.
  - After STEPS = WIDTH/CHUNK slices, go to FIN.
  - On that same edge, SUMA, AS and OV are loaded from the working register and final carries.
- RUN ignores START.
- FIN: DONE=1 for exactly this cycle.
  - START=1 here is accepted exactly as in IDLE and goes to RUN.
  - Otherwise go to IDLE.
- Arithmetic is modulo 2^WIDTH.
- SUB=1 computes A + ~B + ~AE.
- OV = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. It is taken from the last slice.
- Output holding:
  - SUMA/AS/OV change only on entry to FIN; they are held through IDLE and the next RUN.
  - The working register is internal and never drives SUMA.
- Reset:
  - RST=1 forces IDLE. BUSY, DONE, SUMA, AS and OV are all 0, and the counter/carry/working registers are cleared.
  - RST has priority over START.
  - Reset mid-RUN aborts the operation: no DONE, and outputs read 0.
- Operand inputs may change freely after the accepting edge.

## Timing

- Reset values: BUSY=0, DONE=0, SUMA=0, AS=0, OV=0, state IDLE.
- Sequence, with START accepted at edge t:
  - BUSY is high for cycles t+1 … t+STEPS.
  - DONE and valid SUMA/AS/OV are visible in cycle t+STEPS+1.
- Latency is STEPS+1 cycles from the START edge to DONE.
- Throughput: back-to-back START in FIN gives one result every STEPS+1 cycles.
- CHUNK=WIDTH: STEPS=1, DONE two cycles after START.
- No combinational path from any input to any output.

## Structure

- Package sumador_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2);
  - a function giving the counter width, ceil(log2(STEPS)) with minimum 1.
- Sub-module fa_chunk (parameter CHUNK):
  - combinational CHUNK-bit ripple of full-adder cells;
  - inputs a, b, ci; outputs s, co and c_msb (carry into the top bit, used for OV).
- Top level holds the FSM, counter, operand shift registers, carry register and output registers.

## Test plan

All cases use WIDTH=8, CHUNK=2 unless noted.
- A=0x3C, B=0x15, AE=0, SUB=0 → SUMA=0x51, AS=0, OV=0.
  - BUSY high 4 cycles; DONE exactly in cycle t+5.
- A=0xFF, B=0x01, AE=0, SUB=0 → SUMA=0x00, AS=1, OV=0.
- A=0x7F, B=0x01 → SUMA=0x80, AS=0, OV=1.
- Subtraction:
  - SUB=1, A=0x05, B=0x07, AE=0 → SUMA=0xFE, AS=0, OV=0.
  - SUB=1, A=0x10, B=0x01, AE=1 → SUMA=0x0E, AS=1.
- Handshake and reset:
  - START pulsed during RUN → ignored; result unchanged.
  - START held in FIN → second operation starts with no idle cycle.
  - RST at the second RUN cycle → BUSY=0 next cycle, no DONE, SUMA=0.
- Parameter sweep: CHUNK ∈ {1,4,8}, WIDTH ∈ {8,16}, 1000 random operands/modes each.
  - Compare against a behavioural A±B±AE model.
  - DONE latency must equal WIDTH/CHUNK+1.
